// File: rtl/one_to_four_demux_reg_bank.sv
// Demux one handshaked word into one of four holding slots. Build option AUTO_INDEX_EN picks the slot from an internal pointer.
// Latency: 1 cycle from accept to out_*/slot_valid. bank_full and in_ready change one cycle after the fourth load.
// Backpressure: in_ready drops while the bank is full or in reset. A consume pulse releases the bank.
module one_to_four_demux_reg_bank #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             consume,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic [3:0]       slot_valid,
    output logic             bank_full,
    output logic             err_overwrite
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic [1:0]       dst;
    logic [3:0]       dst_onehot;
    logic [3:0]       post_vld;
    logic [WIDTH-1:0] slot_q [4];

`ifdef AUTO_INDEX_EN
    logic [1:0] wr_ptr;
    logic       unused_sel;

    // The slot index comes from wr_ptr. in_sel stays on the port so both builds share one pinout.
    assign unused_sel = ^in_sel;
    assign dst        = wr_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 2'd0;
        end else if (accept && consume) begin
            wr_ptr <= 2'd1;
        end else if (accept) begin
            wr_ptr <= wr_ptr + 2'd1;
        end else if (consume) begin
            wr_ptr <= 2'd0;
        end
    end
`else
    assign dst = in_sel;
`endif

    assign accept     = in_valid & in_ready;
    assign dst_onehot = 4'b0001 << dst;
    assign post_vld   = slot_valid | dst_onehot;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                // A consume in the same cycle as an accept restarts the fill, so the bank does not go full.
                if (accept && !consume && (post_vld == 4'b1111)) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (consume) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && (state_q == FILL);
        bank_full = (state_q == FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= '0;
            end
            slot_valid    <= 4'b0000;
            err_overwrite <= 1'b0;
        end else begin
            if (accept) begin
                slot_q[dst] <= in_data;
            end
            if (accept && consume) begin
                slot_valid <= dst_onehot;
            end else if (accept) begin
                slot_valid <= post_vld;
                if (|(slot_valid & dst_onehot)) begin
                    err_overwrite <= 1'b1;
                end
            end else if (consume) begin
                slot_valid <= 4'b0000;
            end
        end
    end

    assign out_a = slot_q[0];
    assign out_b = slot_q[1];
    assign out_c = slot_q[2];
    assign out_d = slot_q[3];

endmodule
